// File: rtl/tdm_demux_1x8_pkg.sv
// Shared constants and state encoding for the 1:8 TDM receive demultiplexer.
package tdm_demux_1x8_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        HUNT = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux_1x8_demux_1x2.sv
// 1:2 steering cell: routes an enable to one of two outputs by select.
module tdm_demux_1x8_demux_1x2 (
    input  logic i_in,
    input  logic i_sel,
    output logic o_y0,
    output logic o_y1
);

    assign o_y0 = i_in & ~i_sel;
    assign o_y1 = i_in &  i_sel;

endmodule

// File: rtl/tdm_demux_1x8.sv
// 1:8 TDM demultiplexer: aligns on sync, fills per-lane registers and
// presents each completed 8-lane frame on a valid/ready output register.
module tdm_demux_1x8
    import tdm_demux_1x8_pkg::*;
#(
    parameter int unsigned LANE_W = 1,
    parameter int unsigned LANES  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANE_W-1:0]         din,
    input  logic                      din_valid,
    input  logic                      din_sync,
    output logic [LANES*LANE_W-1:0]   lane_out,
    output logic [SEL_W-1:0]          slot,
    output logic [LANES*LANE_W-1:0]   frame_data,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic                      sync_err,
    output logic                      overrun,
    input  logic                      clr_overrun
);

    state_e                     r_state;
    state_e                     w_state_d;
    logic [SEL_W-1:0]           r_slot;
    logic [SEL_W-1:0]           w_slot_d;
    logic [LANES*LANE_W-1:0]    r_lane;
    logic [LANES*LANE_W-1:0]    w_lane_d;
    logic [LANES*LANE_W-1:0]    r_frame;
    logic [LANES*LANE_W-1:0]    w_frame_d;
    logic                       r_frame_valid;
    logic                       w_frame_valid_d;
    logic                       r_sync_err;
    logic                       w_sync_err_d;
    logic                       r_overrun;
    logic                       w_overrun_d;

    logic                       w_accept;
    logic [SEL_W-1:0]           w_wr_slot;
    logic                       w_complete;
    logic                       w_load;
    logic                       w_drop;
    logic [1:0]                 w_en_l1;
    logic [3:0]                 w_en_l2;
    logic [7:0]                 w_we;

    // A sync beat always lands in slot 0, whatever slot was expected.
    assign w_accept  = din_valid & ((r_state == FILL) | din_sync);
    assign w_wr_slot = din_sync ? '0 : r_slot;

    tdm_demux_1x8_demux_1x2 u_dmx_l0 (
        .i_in  (w_accept),
        .i_sel (w_wr_slot[2]),
        .o_y0  (w_en_l1[0]),
        .o_y1  (w_en_l1[1])
    );

    for (genvar j = 0; j < 2; j++) begin : g_l1
        tdm_demux_1x8_demux_1x2 u_dmx (
            .i_in  (w_en_l1[j]),
            .i_sel (w_wr_slot[1]),
            .o_y0  (w_en_l2[2*j]),
            .o_y1  (w_en_l2[2*j+1])
        );
    end

    for (genvar k = 0; k < 4; k++) begin : g_l2
        tdm_demux_1x8_demux_1x2 u_dmx (
            .i_in  (w_en_l2[k]),
            .i_sel (w_wr_slot[0]),
            .o_y0  (w_we[2*k]),
            .o_y1  (w_we[2*k+1])
        );
    end

    assign w_complete = w_accept & (w_wr_slot == SEL_W'(LANES - 1));
    assign w_load     = w_complete & (~r_frame_valid | frame_ready);
    assign w_drop     = w_complete & r_frame_valid & ~frame_ready;

    always_comb begin
        w_lane_d = r_lane;
        for (int i = 0; i < LANES; i++) begin
            if (w_we[i]) begin
                w_lane_d[i*LANE_W +: LANE_W] = din;
            end
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_slot_d        = r_slot;
        w_frame_d       = r_frame;
        w_frame_valid_d = r_frame_valid;
        w_sync_err_d    = 1'b0;
        w_overrun_d     = r_overrun;

        unique case (r_state)
            HUNT: begin
                if (w_accept) begin
                    w_state_d = FILL;
                end
            end
            FILL: begin
                if (din_valid & din_sync & (r_slot != '0)) begin
                    w_sync_err_d = 1'b1;
                end
            end
            default: w_state_d = HUNT;
        endcase

        if (w_accept) begin
            w_slot_d = w_wr_slot + SEL_W'(1);
        end

        // Frame includes the slot-7 beat accepted on this same edge.
        if (w_load) begin
            w_frame_d       = w_lane_d;
            w_frame_valid_d = 1'b1;
        end else if (r_frame_valid & frame_ready) begin
            w_frame_valid_d = 1'b0;
        end

        if (w_drop) begin
            w_overrun_d = 1'b1;
        end else if (clr_overrun) begin
            w_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_slot        <= '0;
            r_lane        <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_slot        <= w_slot_d;
            r_lane        <= w_lane_d;
            r_frame       <= w_frame_d;
            r_frame_valid <= w_frame_valid_d;
            r_sync_err    <= w_sync_err_d;
            r_overrun     <= w_overrun_d;
        end
    end

    assign lane_out    = r_lane;
    assign slot        = r_slot;
    assign frame_data  = r_frame;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed self-checking bench for tdm_demux_1x8 with LANE_W=1.
module tb_tdm_demux_1x8;

    logic       clk;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       din_sync;
    logic [7:0] lane_out;
    logic [2:0] slot;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       frame_ready;
    logic       sync_err;
    logic       overrun;
    logic       clr_overrun;

    int n_checks = 0;
    int n_errors = 0;

    tdm_demux_1x8 #(
        .LANE_W (1),
        .LANES  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_sync    (din_sync),
        .lane_out    (lane_out),
        .slot        (slot),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sync_err    (sync_err),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One valid beat; returns 1 time unit after the accepting edge.
    task automatic beat(input logic d, input logic s);
        @(negedge clk);
        din       = d;
        din_valid = 1'b1;
        din_sync  = s;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sync  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] v);
        for (int i = 0; i < 8; i++) beat(v[i], i == 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        din_sync    = 1'b0;
        frame_ready = 1'b1;
        clr_overrun = 1'b0;
        #12;
        chk("rst_lane", lane_out, 8'h00);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_slot", slot, 3'd0);
        chk("rst_fd", frame_data, 8'h00);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_serr", sync_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // HUNT discards beats without sync
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
        chk("hunt_lane", lane_out, 8'h00);
        chk("hunt_fv", frame_valid, 1'b0);
        chk("hunt_slot", slot, 3'd0);

        // Bits 1,0,1,1,0,0,1,0 for slots 0..7
        send_frame(8'h4D);
        chk("f1_fv", frame_valid, 1'b1);
        chk("f1_fd", frame_data, 8'h4D);
        chk("f1_slot", slot, 3'd0);
        chk("f1_lane", lane_out, 8'h4D);
        idle();
        chk("f1_fv_drop", frame_valid, 1'b0);

        // Sync arriving at slot 5 restarts the frame
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0);
        chk("mid_slot5", slot, 3'd5);
        beat(1'b0, 1'b1);
        chk("serr_pulse", sync_err, 1'b1);
        chk("serr_slot", slot, 3'd1);
        chk("serr_fv", frame_valid, 1'b0);
        for (int i = 1; i < 8; i++) beat((i >= 5) ? 1'b1 : 1'b0, 1'b0);
        chk("serr_clear", sync_err, 1'b0);
        chk("serr_fd", frame_data, 8'hE0);
        chk("serr_fv2", frame_valid, 1'b1);
        idle();
        chk("serr_fv3", frame_valid, 1'b0);

        // Back-pressure: second frame dropped, overrun set
        frame_ready = 1'b0;
        send_frame(8'hA5);
        chk("bp_fv", frame_valid, 1'b1);
        chk("bp_fd", frame_data, 8'hA5);
        chk("bp_ovr0", overrun, 1'b0);
        send_frame(8'h3C);
        chk("ovr_fd", frame_data, 8'hA5);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_fv", frame_valid, 1'b1);
        @(negedge clk);
        frame_ready = 1'b1;
        idle();
        frame_ready = 1'b0;
        chk("ovr_consume", frame_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);
        @(negedge clk);
        clr_overrun = 1'b1;
        idle();
        clr_overrun = 1'b0;
        chk("ovr_clr", overrun, 1'b0);

        // Consume and complete on the same edge
        send_frame(8'h5A);
        chk("se_fd0", frame_data, 8'h5A);
        for (int i = 0; i < 7; i++) beat(8'h96 >> i, i == 0);
        chk("se_hold", frame_data, 8'h5A);
        @(negedge clk);
        frame_ready = 1'b1;
        beat(1'b1, 1'b0);
        chk("se_fv", frame_valid, 1'b1);
        chk("se_fd", frame_data, 8'h96);
        chk("se_ovr", overrun, 1'b0);

        // Async reset mid-frame with a pending frame
        frame_ready = 1'b0;
        idle();
        send_frame(8'h11);
        for (int i = 0; i < 4; i++) beat(1'b1, i == 0);
        chk("pre_rst_slot", slot, 3'd4);
        chk("pre_rst_fv", frame_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lane", lane_out, 8'h00);
        chk("arst_fd", frame_data, 8'h00);
        chk("arst_fv", frame_valid, 1'b0);
        chk("arst_slot", slot, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b0);
        chk("post_rst_lane", lane_out, 8'h00);
        chk("post_rst_slot", slot, 3'd0);
        chk("post_rst_fv", frame_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Receive-side counterpart of the 8:1 lane multiplexer: takes a time-division-multiplexed stream, one lane per valid beat, slot 0 marked by sync.
- Steers each beat to lane slot 0..7 (binary 1:8 demux tree), holds per-lane values and assembles complete 8-lane frames.
- Presents each completed frame on a valid/ready output.
- Sits between the serial link receiver and the lane consumers.

Parameters:
- LANE_W, 1, width of one lane sample (din width).
- LANES, 8, lane count; fixed at 8 (SEL_W = 3); other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  LANE_W  TDM sample
- din_valid  input  1  din is a valid beat this cycle
- din_sync  input  1  qualifies the current valid beat as slot 0; ignored when din_valid=0
- lane_out  output  LANES*LANE_W  per-lane hold registers; lane i at bits [i*LANE_W +: LANE_W]
- slot  output  3  slot index the next valid beat will occupy
- frame_data  output  LANES*LANE_W  last completed frame, same packing as lane_out
- frame_valid  output  1  frame_data holds an unconsumed frame
- frame_ready  input  1  consumer accepts frame_data when frame_valid=1
- sync_err  output  1  one-cycle pulse: sync arrived mid-frame
- overrun  output  1  sticky: a completed frame was dropped
- clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst_n=0): lane_out=0, frame_data=0, frame_valid=0, slot=0, sync_err=0, overrun=0, state=HUNT, fill buffer=0.
- States:
  - HUNT: all beats without sync are discarded.
  - FILL: collecting slots 0..7.
- HUNT -> FILL: on din_valid&din_sync; the beat is stored as slot 0; slot becomes 1.
- FILL, din_valid&!din_sync:
  - Beat goes to slot; lane_out[slot] and fill[slot] update on the same edge.
  - slot increments modulo 8.
- FILL, din_valid&din_sync:
  - slot==0: normal frame start.
  - slot!=0: partial frame discarded; sync_err pulses one cycle; beat stored as slot 0; slot becomes 1; stay in FILL.
- Frame completion: the beat stored at slot 7 completes the frame; slot wraps to 0; stay in FILL. The next frame expects sync at slot 0.
- FILL, din_valid&!din_sync at slot 0: accepted as slot 0 (free-running alignment after first sync). No error.
- Latency:
  - lane_out updates on the edge that accepts the beat.
  - frame_valid rises on the edge accepting slot 7, so frame_data includes that beat.
- Output handshake:
  - frame_valid stays high and frame_data stays stable until frame_valid&frame_ready.
  - On that edge frame_valid falls, unless a new frame completes the same edge.
- Completion vs. output register:
  - Completion while frame_valid&!frame_ready: the new frame is dropped, frame_data is unchanged, overrun=1.
  - Completion while frame_ready=1 or frame_valid=0: frame loaded, frame_valid=1, no overrun.
- overrun: stays set until clr_overrun=1. If clr_overrun and a new overrun occur on the same edge, set wins.
- din_valid=0: no state change; slot holds.
- Gaps between beats are unlimited.
- Reset mid-frame: partial frame and pending frame_valid are lost; the block returns to HUNT.

Decomposition:
- Shared package/include holds: LANES=8, SEL_W=3, state encodings HUNT=1'b0, FILL=1'b1.
- Natural sub-module: demux_1x2 (one input, select, two enable outputs).
  - Instantiated as a 3-level tree (7 cells) decoding slot into 8 lane write-enables.
  - Mirrors the 2:1-cell structure of the transmit mux.

Test Plan:
- Reset, then 3 valid beats without sync -> lane_out=0, frame_valid=0, slot=0 (HUNT discards).
- LANE_W=1, frame_ready=1:
  - Stimulus: sync on beat 0, bits 1,0,1,1,0,0,1,0 for slots 0..7.
  - Required: frame_valid pulses the cycle after slot 7 accepted; frame_data=8'b0100_1101; slot=0.
- Sync asserted at slot 5 -> sync_err one-cycle pulse; slot=1; the prior 5 beats never appear in frame_data.
- frame_ready=0, two complete frames (0xA5 then 0x3C):
  - Required: frame_data stays 0xA5; overrun=1.
  - Then frame_ready=1 for one cycle -> frame_valid=0.
  - Then clr_overrun -> overrun=0.
- Same-edge frame_ready=1 and slot-7 completion -> frame_valid stays 1; frame_data switches to the new frame; overrun=0.
- rst_n low mid-frame at slot 4 with frame_valid=1 -> all outputs 0 immediately (async); after release, a beat without sync is discarded.
